// File: rtl/serial_borrow_subtractor.sv
// -----------------------------------------------------------------------------
// serial_borrow_subtractor
//
// Bit-serial subtractor that computes DIFF = A - B - BIn, LSB first. It uses one
// full-subtractor cell and a borrow flip-flop, so an operation takes WIDTH clocks.
// A start/busy/done handshake controls it. It sits beside the carry-select adder
// in the ALU datapath.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; only sampled in IDLE or DONE
//   A       in   WIDTH  minuend, captured when start is accepted
//   B       in   WIDTH  subtrahend, captured when start is accepted
//   BIn     in   1      borrow-in, captured when start is accepted
//   DIFF    out  WIDTH  registered result; holds until the next completion
//   BOut    out  1      registered borrow-out (unsigned A < B + BIn)
//   OVF     out  1      registered two's-complement overflow
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse; results are valid from this cycle
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results hold the last completed operation
// SHIFT  | one bit per clock through the full-subtractor cell
// DONE   | one-cycle completion pulse; start here reloads without a gap
// -----------------------------------------------------------------------------
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIn,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOut,
  output logic             OVF,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers, the partial result and the bit counter.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 result bits are held here. The final bit comes straight from
  // the cell on the completing edge.
  logic [WIDTH-2:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  // Operand sign bits. They are kept for the overflow flag, because the
  // operand registers have shifted out by the time the result lands.
  logic             a_msb;
  logic             b_msb;

  logic             load;
  logic             last_bit;
  logic             bit_a;
  logic             bit_b;
  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] d_full;
  logic             ovf_nxt;

  // Start is accepted only in IDLE or DONE. A start during SHIFT is dropped.
  assign load     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (state == S_SHIFT) && (cnt == CNT_LAST);

  // Full-subtractor cell
  assign bit_a  = a_sr[0];
  assign bit_b  = b_sr[0];
  assign bit_d  = bit_a ^ bit_b ^ br;
  assign br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);

  // The result fills from the MSB end, so after WIDTH shifts bit 0 is the LSB.
  assign d_full = {bit_d, d_sr};

  // Signed overflow: the operands have different signs and the result sign
  // differs from the minuend sign. BIn counts as part of the subtrahend.
  assign ovf_nxt = (a_msb != b_msb) && (bit_d != a_msb);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = start ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture and bit-serial shift
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (load) begin
      a_sr  <= A;
      b_sr  <= B;
      d_sr  <= '0;
      br    <= BIn;
      cnt   <= '0;
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_full[WIDTH-1:1];
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers. They update only on the completing edge, so they hold
  // the previous result for the whole of SHIFT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DIFF <= '0;
      BOut <= 1'b0;
      OVF  <= 1'b0;
    end else if (last_bit) begin
      DIFF <= d_full;
      BOut <= br_nxt;
      OVF  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
module tb_serial_borrow_subtractor;

  localparam int W = 4;
  localparam int PERIOD = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BIn;
  logic [W-1:0] DIFF;
  logic         BOut;
  logic         OVF;
  logic         busy;
  logic         done;

  int           n_checks = 0;
  int           n_fail   = 0;

  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;
  logic         prev_ovf  = 1'b0;
  time          t_last_done = 0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIn   (BIn),
    .DIFF  (DIFF),
    .BOut  (BOut),
    .OVF   (OVF),
    .busy  (busy),
    .done  (done)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the unsigned and signed values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int u, sa, sb, s;
    u  = int'(a) - int'(b) - int'(bin);
    d  = W'(u);
    bo = (u < 0);
    sa = int'(a) - (a[W-1] ? (1 << W) : 0);
    sb = int'(b) - (b[W-1] ? (1 << W) : 0);
    s  = sa - sb - int'(bin);
    ov = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
  endfunction

  // Runs one operation. If pre_driven is set, the caller has already put the
  // inputs and start=1 on the pins during the current cycle.
  // glitch_at >= 0 pulses start (A=1, B=1) at that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit pre_driven, input int glitch_at);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           k;
    model(a, b, bin, ed, eb, eo);
    if (!pre_driven) begin
      @(negedge clk);
      A = a; B = b; BIn = bin; start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    A   = W'($urandom);
    B   = W'($urandom);
    BIn = 1'($urandom);
    k = 0;
    @(negedge clk);
    while (!done && k < 20) begin
      check("busy_shift", busy, 1);
      check("diff_hold", DIFF, prev_diff);
      check("bout_hold", BOut, prev_bout);
      if (k == glitch_at) begin
        start = 1'b1; A = 1; B = 1; BIn = 1'b0;
      end else if (glitch_at >= 0) begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check("latency", k, W);
    check("busy_in_done", busy, 0);
    check("diff", DIFF, ed);
    check("bout", BOut, eb);
    check("ovf", OVF, eo);
    prev_diff = ed;
    prev_bout = eb;
    prev_ovf  = eo;
    t_last_done = $time;
  endtask

  initial begin
    time t1;
    int  seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; BIn = 1'b0;
    #12;
    check("rst_diff", DIFF, 0);
    check("rst_bout", BOut, 0);
    check("rst_ovf", OVF, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic cases and boundaries
    run_op(4'd13, 4'd12, 1'b0, 0, -1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    run_op(4'd12, 4'd13, 1'b0, 0, -1);
    run_op(4'd0, 4'd0, 1'b1, 0, -1);
    run_op(4'd8, 4'd1, 1'b0, 0, -1);
    run_op(4'd7, 4'd8, 1'b0, 0, -1);

    // A start during SHIFT is ignored
    run_op(4'd9, 4'd3, 1'b0, 0, 1);

    // Back-to-back start in the done cycle
    run_op(4'd5, 4'd2, 1'b0, 0, -1);
    start = 1'b1; A = 4'd10; B = 4'd4; BIn = 1'b0;
    t1 = t_last_done;
    run_op(4'd10, 4'd4, 1'b0, 1, -1);
    check("b2b_gap", int'(t_last_done - t1), 5 * PERIOD);

    // Reset during SHIFT
    @(negedge clk);
    A = 4'd3; B = 4'd1; BIn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_diff", DIFF, 0);
    check("midrst_bout", BOut, 0);
    check("midrst_ovf", OVF, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    run_op(4'd15, 4'd15, 1'b0, 0, -1);

    // Randomized operations, some back-to-back
    repeat (40) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1; A = ra; B = rb; BIn = rbin;
        run_op(ra, rb, rbin, 1, -1);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_op(ra, rb, rbin, 0, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
